// File: rtl/counter_pkg.sv
// Shared constants for the programmable up/down event counter.
package counter_pkg;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DN    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage : counter_pkg

// File: rtl/counter_prescaler.sv
// Step prescaler: emits one step strobe per (i_presc+1) enabled cycles.
module counter_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [PRESC_W-1:0] i_presc,
  output logic               step
);

  logic [PRESC_W-1:0] phase_q;

  // >= rather than == so lowering i_presc below the current phase
  // steps on the next enable instead of running the phase around.
  assign step = enable && (phase_q >= i_presc);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
    end else if (clear) begin
      phase_q <= '0;
    end else if (enable) begin
      phase_q <= step ? '0 : phase_q + 1'b1;
    end
  end

endmodule : counter_prescaler

// File: rtl/counter_prog_updown.sv
// Programmable up/down counter with terminal value, wrap/saturate mode,
// synchronous load, step prescaler, terminal tick and sticky overflow flag.
module counter_prog_updown
  import counter_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter int                 PRESC_W   = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clk_en,
  input  logic               i_count_valid,
  input  logic               i_dir,
  input  logic               i_mode,
  input  logic               i_load,
  input  logic [WIDTH-1:0]   i_load_val,
  input  logic [WIDTH-1:0]   i_max,
  input  logic [PRESC_W-1:0] i_presc,
  input  logic               i_clr_ovf,
  output logic [WIDTH-1:0]   o_count,
  output logic               o_count_end,
  output logic               o_tick,
  output logic               o_ovf
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nxt;
  logic             tick_q;
  logic             ovf_q;
  logic             load;
  logic             qual_valid;
  logic             step;
  logic             terminal;

  assign load       = i_clk_en && i_load;
  assign qual_valid = i_clk_en && i_count_valid && !i_load;

  counter_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk     (clk),
    .reset   (reset),
    .enable  (qual_valid),
    .clear   (load),
    .i_presc (i_presc),
    .step    (step)
  );

  assign o_count_end = (i_dir == DIR_UP) ? (count_q >= i_max) : (count_q == '0);
  assign terminal    = step && o_count_end;

  // NOTE: count_nxt is defaulted before any branch so the block stays
  // purely combinational and no latch is inferred.
  always_comb begin
    count_nxt = count_q;
    if (load) begin
      count_nxt = i_load_val;
    end else if (step) begin
      if (i_dir == DIR_UP) begin
        if (count_q < i_max) count_nxt = count_q + 1'b1;
        else                 count_nxt = (i_mode == MODE_SAT) ? i_max : '0;
      end else begin
        if (count_q != '0)   count_nxt = count_q - 1'b1;
        else                 count_nxt = (i_mode == MODE_WRAP) ? i_max : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RESET_VAL;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // terminal already carries i_clk_en, so the tick drops when gated off
      tick_q <= terminal;
      if (i_clk_en) count_q <= count_nxt;
      if (terminal)                     ovf_q <= 1'b1;
      else if (i_clk_en && i_clr_ovf)   ovf_q <= 1'b0;
    end
  end

  assign o_count = count_q;
  assign o_tick  = tick_q;
  assign o_ovf   = ovf_q;

endmodule : counter_prog_updown
